viterbi_acs_ctrl: RTL and testbench

VITERBI_ACS_CTRL -- requirements
Module: viterbi_acs_ctrl

---
 rtl/viterbi_pkg.sv | 23 ++
 rtl/viterbi_acs_ctrl_if.sv | 46 ++++
 rtl/viterbi_step_cnt.sv | 48 ++++
 rtl/viterbi_acs_ctrl.sv | 210 +++++++++++++++++++++
 tb/tb_viterbi_acs_ctrl.sv | 348 ++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/viterbi_pkg.sv
// Shared definitions for the Viterbi ACS array controller.
//   state_t        controller FSM encoding
//   NUM_STATES     trellis states covered by the ACS array
//   WIDTH_BM       branch-metric width delivered by the BMU
//   LEN_W_DEF      default width of block length / step counters
//   NUM_GRP_DEF    default number of ACS state groups per trellis step
package viterbi_pkg;

  localparam int NUM_STATES  = 64;
  localparam int WIDTH_BM    = 9;
  localparam int LEN_W_DEF   = 12;
  localparam int NUM_GRP_DEF = 4;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_CLR     = 3'd1,
    ST_RUN     = 3'd2,
    ST_TB_REQ  = 3'd3,
    ST_TB_WAIT = 3'd4,
    ST_DONE    = 3'd5
  } state_t;

endpackage

// File: rtl/viterbi_acs_ctrl_if.sv
// Bundle of control, handshake and ACS-array strobes around viterbi_acs_ctrl.
//   master : block/symbol/traceback source side (drives *_i, observes *_o)
//   slave  : the controller itself
interface viterbi_acs_ctrl_if
  import viterbi_pkg::*;
#(
  parameter int NUM_GRP = NUM_GRP_DEF,
  parameter int LEN_W   = LEN_W_DEF
);
  localparam int GRP_W = (NUM_GRP > 1) ? $clog2(NUM_GRP) : 1;

  logic             start_i;
  logic             abort_i;
  logic [LEN_W-1:0] block_len_i;
  logic             tail_biting_en_i;
  logic             sym_valid_i;
  logic             sym_ready_o;
  logic             tb_done_i;
  logic             pm_msb_any_i;
  logic             acs_en_o;
  logic             rst_sync_o;
  logic             is_t0_o;
  logic             bm_valid_o;
  logic [GRP_W-1:0] state_grp_o;
  logic [LEN_W-1:0] step_o;
  logic             pass_o;
  logic             tb_start_o;
  logic             done_o;
  logic             busy_o;
  logic             norm_o;

  modport master (
    output start_i, abort_i, block_len_i, tail_biting_en_i, sym_valid_i,
           tb_done_i, pm_msb_any_i,
    input  sym_ready_o, acs_en_o, rst_sync_o, is_t0_o, bm_valid_o,
           state_grp_o, step_o, pass_o, tb_start_o, done_o, busy_o, norm_o
  );

  modport slave (
    input  start_i, abort_i, block_len_i, tail_biting_en_i, sym_valid_i,
           tb_done_i, pm_msb_any_i,
    output sym_ready_o, acs_en_o, rst_sync_o, is_t0_o, bm_valid_o,
           state_grp_o, step_o, pass_o, tb_start_o, done_o, busy_o, norm_o
  );

endinterface

// File: rtl/viterbi_step_cnt.sv
// Group / trellis-step sequencer for the ACS controller.
//   clk_i, rst_i   clock, asynchronous active-high reset
//   clr            zero both counters
//   grp_inc        advance the group counter (wraps after NUM_GRP-1)
//   step_inc       advance the step counter
//   step_clr       restart the step counter (second tail-biting pass)
//   len            latched block length (never 0 while running)
//   grp, step      counter values
//   grp_last       group counter at NUM_GRP-1
//   step_last      step counter at len-1
module viterbi_step_cnt
  import viterbi_pkg::*;
#(
  parameter int NUM_GRP = NUM_GRP_DEF,
  parameter int LEN_W   = LEN_W_DEF
) (
  input  logic                                        clk_i,
  input  logic                                        rst_i,
  input  logic                                        clr,
  input  logic                                        grp_inc,
  input  logic                                        step_inc,
  input  logic                                        step_clr,
  input  logic [LEN_W-1:0]                            len,
  output logic [((NUM_GRP > 1) ? $clog2(NUM_GRP) : 1)-1:0] grp,
  output logic [LEN_W-1:0]                            step,
  output logic                                        grp_last,
  output logic                                        step_last
);
  localparam int GRP_W = (NUM_GRP > 1) ? $clog2(NUM_GRP) : 1;

  assign grp_last  = (grp == GRP_W'(NUM_GRP - 1));
  assign step_last = (step == (len - LEN_W'(1)));

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      grp  <= '0;
      step <= '0;
    end else if (clr) begin
      grp  <= '0;
      step <= '0;
    end else begin
      if (grp_inc) grp <= grp_last ? '0 : grp + GRP_W'(1);
      if (step_clr)      step <= '0;
      else if (step_inc) step <= step + LEN_W'(1);
    end
  end

endmodule

// File: rtl/viterbi_acs_ctrl.sv
// Controller sequencing a 64-state ACS array through one decode block:
// clear, NUM_GRP group cycles per accepted symbol pair, optional second
// tail-biting pass, traceback request/wait and completion pulse.
//   clk_i, rst_i   clock, asynchronous active-high reset
//   bus (slave)    start/abort/length/mode, symbol handshake, traceback
//                  handshake, ACS strobes, step/group/pass, status pulses
// Build option: VITERBI_NORM_EN enables the path-metric normalization strobe
// (norm_o); without it norm_o is constant 0 and pm_msb_any_i is ignored.
// Every output is a register loaded from the next-state logic.
module viterbi_acs_ctrl
  import viterbi_pkg::*;
#(
  parameter int NUM_GRP = NUM_GRP_DEF,
  parameter int LEN_W   = LEN_W_DEF
) (
  input logic               clk_i,
  input logic               rst_i,
  viterbi_acs_ctrl_if.slave bus
);
  localparam int GRP_W = (NUM_GRP > 1) ? $clog2(NUM_GRP) : 1;

  state_t           state_q, state_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic             tbm_q, tbm_d, pass_q, pass_d;
  logic             acs_en_q, busy_q;
  logic             rst_sync_q, rst_sync_d, is_t0_q, is_t0_d;
  logic             bm_valid_q, bm_valid_d, sym_ready_q, sym_ready_d;
  logic             tb_start_q, tb_start_d, done_q, done_d;
  logic             cnt_clr, grp_inc, step_inc, step_clr, accept, burst_end;
  logic [GRP_W-1:0] grp;
  logic [LEN_W-1:0] step;
  logic             grp_last, step_last;
  logic             norm_q;

  viterbi_step_cnt #(.NUM_GRP(NUM_GRP), .LEN_W(LEN_W)) u_step_cnt (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .clr       (cnt_clr),
    .grp_inc   (grp_inc),
    .step_inc  (step_inc),
    .step_clr  (step_clr),
    .len       (len_q),
    .grp       (grp),
    .step      (step),
    .grp_last  (grp_last),
    .step_last (step_last)
  );

  always_comb begin
    state_d     = state_q;
    len_d       = len_q;
    tbm_d       = tbm_q;
    pass_d      = pass_q;
    rst_sync_d  = 1'b0;
    is_t0_d     = 1'b0;
    bm_valid_d  = 1'b0;
    sym_ready_d = 1'b0;
    tb_start_d  = 1'b0;
    done_d      = 1'b0;
    cnt_clr     = 1'b0;
    grp_inc     = 1'b0;
    step_inc    = 1'b0;
    step_clr    = 1'b0;
    accept      = 1'b0;
    burst_end   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (bus.start_i && (bus.block_len_i != '0)) begin
          state_d    = ST_CLR;
          len_d      = bus.block_len_i;
          tbm_d      = bus.tail_biting_en_i;
          pass_d     = 1'b0;
          rst_sync_d = 1'b1;
          cnt_clr    = 1'b1;
        end
      end
      ST_CLR: begin
        state_d     = ST_RUN;
        sym_ready_d = 1'b1;
        cnt_clr     = 1'b1;
      end
      ST_RUN: begin
        if (bm_valid_q) begin
          grp_inc = 1'b1;
          if (grp_last) begin
            burst_end = 1'b1;
            if (!step_last) begin
              step_inc    = 1'b1;
              sym_ready_d = 1'b1;
            end else if (tbm_q && !pass_q) begin
              // Second pass reuses the metrics left by the first pass.
              step_clr    = 1'b1;
              pass_d      = 1'b1;
              sym_ready_d = 1'b1;
            end else begin
              state_d    = ST_TB_REQ;
              tb_start_d = 1'b1;
            end
          end else begin
            bm_valid_d = 1'b1;
            is_t0_d    = is_t0_q;
          end
        end else if (sym_ready_q && bus.sym_valid_i) begin
          accept     = 1'b1;
          bm_valid_d = 1'b1;
          is_t0_d    = (step == '0) && !pass_q;
        end else begin
          sym_ready_d = 1'b1;
        end
      end
      ST_TB_REQ:  state_d = ST_TB_WAIT;
      ST_TB_WAIT: begin
        if (bus.tb_done_i) begin
          state_d = ST_DONE;
          done_d  = 1'b1;
        end
      end
      ST_DONE:    state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase
    // Abort overrides everything decided above.
    if ((state_q != ST_IDLE) && bus.abort_i) begin
      state_d     = ST_IDLE;
      pass_d      = 1'b0;
      rst_sync_d  = 1'b1;
      is_t0_d     = 1'b0;
      bm_valid_d  = 1'b0;
      sym_ready_d = 1'b0;
      tb_start_d  = 1'b0;
      done_d      = 1'b0;
      cnt_clr     = 1'b1;
      grp_inc     = 1'b0;
      step_inc    = 1'b0;
      step_clr    = 1'b0;
      accept      = 1'b0;
      burst_end   = 1'b0;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= ST_IDLE;
      len_q       <= '0;
      tbm_q       <= 1'b0;
      pass_q      <= 1'b0;
      acs_en_q    <= 1'b0;
      busy_q      <= 1'b0;
      rst_sync_q  <= 1'b0;
      is_t0_q     <= 1'b0;
      bm_valid_q  <= 1'b0;
      sym_ready_q <= 1'b0;
      tb_start_q  <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      len_q       <= len_d;
      tbm_q       <= tbm_d;
      pass_q      <= pass_d;
      acs_en_q    <= (state_d == ST_CLR) || (state_d == ST_RUN) ||
                     (state_d == ST_TB_REQ) || (state_d == ST_TB_WAIT);
      busy_q      <= (state_d != ST_IDLE);
      rst_sync_q  <= rst_sync_d;
      is_t0_q     <= is_t0_d;
      bm_valid_q  <= bm_valid_d;
      sym_ready_q <= sym_ready_d;
      tb_start_q  <= tb_start_d;
      done_q      <= done_d;
    end
  end

`ifdef VITERBI_NORM_EN
  // An overflow warning is held until the next accepted step, which then
  // carries norm_o through all of its group cycles.
  logic norm_pend_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      norm_pend_q <= 1'b0;
      norm_q      <= 1'b0;
    end else if ((state_q != ST_RUN) || bus.abort_i) begin
      norm_pend_q <= 1'b0;
      norm_q      <= 1'b0;
    end else if (accept) begin
      norm_q      <= norm_pend_q | bus.pm_msb_any_i;
      norm_pend_q <= 1'b0;
    end else begin
      norm_pend_q <= norm_pend_q | bus.pm_msb_any_i;
      if (burst_end) norm_q <= 1'b0;
    end
  end
`else
  logic unused_norm;
  assign unused_norm = ^{bus.pm_msb_any_i, accept, burst_end};
  assign norm_q      = 1'b0;
`endif

  assign bus.acs_en_o    = acs_en_q;
  assign bus.rst_sync_o  = rst_sync_q;
  assign bus.is_t0_o     = is_t0_q;
  assign bus.bm_valid_o  = bm_valid_q;
  assign bus.sym_ready_o = sym_ready_q;
  assign bus.state_grp_o = grp;
  assign bus.step_o      = step;
  assign bus.pass_o      = pass_q;
  assign bus.tb_start_o  = tb_start_q;
  assign bus.done_o      = done_q;
  assign bus.busy_o      = busy_q;
  assign bus.norm_o      = norm_q;

endmodule

// File: tb/tb_viterbi_acs_ctrl.sv
// Self-checking bench for viterbi_acs_ctrl: randomized symbol handshakes and
// traceback latencies compared against a trellis-schedule model.
// Honours VITERBI_NORM_EN the same way as the design.
module tb_viterbi_acs_ctrl;
  localparam int NUM_GRP = 4;
  localparam int LEN_W   = 12;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  viterbi_acs_ctrl_if #(.NUM_GRP(NUM_GRP), .LEN_W(LEN_W)) bus ();

  viterbi_acs_ctrl #(.NUM_GRP(NUM_GRP), .LEN_W(LEN_W)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus.slave)
  );

  int checks = 0;
  int errors = 0;

  int act_beats[$];
  int exp_beats[$];
  int n_rst_sync, n_tb_start, n_done, n_accept, n_norm_beats, n_norm_other;
  int first_norm_beat, ready_in_burst, no_burst_after_acc, spurious_burst;
  int acs_bad, done_lat_bad;
  bit timed_out, clr_ok;

  function automatic int enc(int g, int s, int p, int t);
    return g + s * 16 + p * 65536 + t * 131072;
  endfunction

  // Expected schedule: every pass walks every step, every step every group;
  // only step 0 of the first pass is the trellis origin.
  function automatic void build_model(int len, bit tbm);
    exp_beats.delete();
    for (int p = 0; p < (tbm ? 2 : 1); p++)
      for (int s = 0; s < len; s++)
        for (int g = 0; g < NUM_GRP; g++)
          exp_beats.push_back(enc(g, s, p, (p == 0 && s == 0) ? 1 : 0));
  endfunction

  function automatic int beat_diffs();
    int d = 0;
    if (act_beats.size() != exp_beats.size()) return 1000 + act_beats.size();
    foreach (exp_beats[i]) if (act_beats[i] != exp_beats[i]) d++;
    return d;
  endfunction

  function automatic logic [23:0] outs();
    return {bus.acs_en_o, bus.rst_sync_o, bus.is_t0_o, bus.bm_valid_o,
            bus.state_grp_o, bus.step_o, bus.pass_o, bus.tb_start_o,
            bus.done_o, bus.busy_o, bus.norm_o, bus.sym_ready_o};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.start_i = 1'b0; bus.abort_i = 1'b0; bus.block_len_i = '0;
    bus.tail_biting_en_i = 1'b0; bus.sym_valid_i = 1'b0;
    bus.tb_done_i = 1'b0; bus.pm_msb_any_i = 1'b0;
  endtask

  // Runs one block to completion and records what was observed.
  // vmode: 0 valid held high, 1 toggling, 2 random.
  task automatic run_block(input int len, input bit tbm, input int vmode,
                           input int pm_beat, input bit noise);
    bit sv = 1'b0, prev_bm = 1'b0, acc, fin = 1'b0, seen_tbs = 1'b0;
    int cyc = 0, tbd_wait = -1, tbd_edge = -1;
    act_beats.delete();
    n_rst_sync = 0; n_tb_start = 0; n_done = 0; n_accept = 0;
    n_norm_beats = 0; n_norm_other = 0; first_norm_beat = -1;
    ready_in_burst = 0; no_burst_after_acc = 0; spurious_burst = 0;
    acs_bad = 0; done_lat_bad = 0; clr_ok = 1'b1;
    while (!fin && cyc < 600) begin
      if (cyc == 0) begin
        bus.start_i = 1'b1;
        bus.block_len_i = LEN_W'(len);
        bus.tail_biting_en_i = tbm;
      end else begin
        bus.start_i = noise && ($urandom_range(0, 3) == 0);
        if (noise) begin
          bus.block_len_i = LEN_W'($urandom_range(0, 9));
          bus.tail_biting_en_i = 1'($urandom_range(0, 1));
        end
      end
      case (vmode)
        0:       sv = 1'b1;
        1:       sv = !sv;
        default: sv = 1'($urandom_range(0, 1));
      endcase
      bus.sym_valid_i = sv;
      if (tbd_wait == 0) begin
        bus.tb_done_i = 1'b1;
        tbd_edge = cyc + 1;
        tbd_wait = -1;
      end else begin
        bus.tb_done_i = noise && !seen_tbs && (cyc > 0) && ($urandom_range(0, 4) == 0);
        if (tbd_wait > 0) tbd_wait--;
      end
      bus.pm_msb_any_i = (pm_beat >= 0) && prev_bm && (act_beats.size() == pm_beat + 1);
      acc = sv && bus.sym_ready_o;
      tick();
      cyc++;
      if (bus.bm_valid_o)
        act_beats.push_back(enc(int'(bus.state_grp_o), int'(bus.step_o),
                                int'(bus.pass_o), int'(bus.is_t0_o)));
      if (bus.bm_valid_o && bus.sym_ready_o) ready_in_burst++;
      if (acc) begin
        n_accept++;
        if (!(bus.bm_valid_o && bus.state_grp_o == '0)) no_burst_after_acc++;
      end
      if (bus.bm_valid_o && !prev_bm && !acc) spurious_burst++;
      prev_bm = bus.bm_valid_o;
      if (bus.rst_sync_o) n_rst_sync++;
      if (bus.tb_start_o) begin
        n_tb_start++;
        seen_tbs = 1'b1;
        tbd_wait = $urandom_range(1, 3);
      end
      if (bus.done_o) begin
        n_done++;
        if (cyc != tbd_edge) done_lat_bad++;
      end
      if (bus.acs_en_o !== (bus.busy_o && !bus.done_o)) acs_bad++;
      if (bus.norm_o) begin
        if (bus.bm_valid_o) begin
          if (n_norm_beats == 0) first_norm_beat = act_beats.size() - 1;
          n_norm_beats++;
        end else n_norm_other++;
      end
      if (cyc == 1 && !(bus.rst_sync_o && bus.acs_en_o && bus.busy_o &&
                        !bus.sym_ready_o && !bus.bm_valid_o)) clr_ok = 1'b0;
      if (cyc == 2 && !(bus.sym_ready_o && !bus.rst_sync_o && bus.busy_o)) clr_ok = 1'b0;
      if (cyc > 1 && !bus.busy_o) fin = 1'b1;
    end
    timed_out = !fin;
    idle_inputs();
  endtask

  task automatic test_reset();
    int bad = 0;
    idle_inputs();
    rst = 1'b1;
    tick(); tick();
    checks++;
    if (outs() !== 24'h0) begin errors++; $display("FAIL reset_state: got %h want 0", outs()); end
    rst = 1'b0;
    tick();
    // Reset in the middle of a block.
    bus.block_len_i = 5; bus.sym_valid_i = 1'b1; bus.start_i = 1'b1;
    tick();
    bus.start_i = 1'b0;
    for (int i = 0; i < 9; i++) tick();
    #2 rst = 1'b1;
    #1;
    checks++;
    if (outs() !== 24'h0) begin errors++; $display("FAIL reset_midblock: got %h want 0", outs()); end
    tick(); tick();
    rst = 1'b0;
    for (int i = 0; i < 12; i++) begin
      bus.tb_done_i = 1'($urandom_range(0, 1));
      tick();
      if (bus.tb_start_o || bus.done_o || bus.busy_o) bad++;
    end
    idle_inputs();
    checks++;
    if (bad !== 0) begin errors++; $display("FAIL reset_discard: got %0d pulses want 0", bad); end
  endtask

  task automatic test_basic();
    int d;
    run_block(3, 1'b0, 0, -1, 1'b0);
    build_model(3, 1'b0);
    d = beat_diffs();
    checks++;
    if (d !== 0) begin errors++; $display("FAIL basic_beats: got %0d beats (%0d off) want %0d", act_beats.size(), d, exp_beats.size()); end
    checks++;
    if (timed_out !== 1'b0) begin errors++; $display("FAIL basic_timeout: got timeout want completion"); end
    checks++;
    if (clr_ok !== 1'b1) begin errors++; $display("FAIL basic_clr: got bad CLR/RUN entry want rst_sync+acs_en then ready"); end
    checks++;
    if (n_rst_sync !== 1) begin errors++; $display("FAIL basic_rst_sync: got %0d want 1", n_rst_sync); end
    checks++;
    if (n_tb_start !== 1) begin errors++; $display("FAIL basic_tb_start: got %0d want 1", n_tb_start); end
    checks++;
    if (n_done !== 1 || done_lat_bad !== 0) begin errors++; $display("FAIL basic_done: got %0d (late %0d) want 1 (late 0)", n_done, done_lat_bad); end
    checks++;
    if (acs_bad !== 0) begin errors++; $display("FAIL basic_acs_en: got %0d bad cycles want 0", acs_bad); end
  endtask

  task automatic test_tail_biting();
    int d;
    run_block(2, 1'b1, 0, -1, 1'b0);
    build_model(2, 1'b1);
    d = beat_diffs();
    checks++;
    if (d !== 0) begin errors++; $display("FAIL tb_beats: got %0d beats (%0d off) want %0d", act_beats.size(), d, exp_beats.size()); end
    checks++;
    if (n_accept !== 4 || n_done !== 1 || n_tb_start !== 1) begin
      errors++; $display("FAIL tb_counts: got acc %0d done %0d tbs %0d want 4 1 1", n_accept, n_done, n_tb_start);
    end
  endtask

  task automatic test_stall();
    int d, len;
    bit tbm;
    len = $urandom_range(2, 5);
    tbm = 1'($urandom_range(0, 1));
    run_block(len, tbm, 1, -1, 1'b0);
    build_model(len, tbm);
    d = beat_diffs();
    checks++;
    if (d !== 0) begin errors++; $display("FAIL stall_beats: got %0d beats (%0d off) want %0d", act_beats.size(), d, exp_beats.size()); end
    checks++;
    if (ready_in_burst !== 0) begin errors++; $display("FAIL stall_ready: got %0d ready-in-burst cycles want 0", ready_in_burst); end
    checks++;
    if (spurious_burst !== 0 || no_burst_after_acc !== 0) begin
      errors++; $display("FAIL stall_handshake: got spurious %0d missed %0d want 0 0", spurious_burst, no_burst_after_acc);
    end
    checks++;
    if (n_accept !== len * (tbm ? 2 : 1)) begin errors++; $display("FAIL stall_accepts: got %0d want %0d", n_accept, len * (tbm ? 2 : 1)); end
  endtask

  task automatic test_random();
    int d, len;
    bit tbm;
    for (int k = 0; k < 4; k++) begin
      len = $urandom_range(1, 6);
      tbm = 1'($urandom_range(0, 1));
      run_block(len, tbm, 2, -1, 1'b0);
      build_model(len, tbm);
      d = beat_diffs();
      checks++;
      if (d !== 0 || n_done !== 1) begin
        errors++; $display("FAIL random_block%0d: got %0d beats (%0d off) done %0d want %0d beats done 1", k, act_beats.size(), d, n_done, exp_beats.size());
      end
    end
  endtask

  task automatic test_ignore();
    int d, nb = 0, len;
    bit tbm;
    bus.block_len_i = '0; bus.start_i = 1'b1; bus.sym_valid_i = 1'b1;
    tick();
    bus.start_i = 1'b0;
    if (bus.busy_o) nb++;
    for (int i = 0; i < 4; i++) begin tick(); if (bus.busy_o || bus.rst_sync_o) nb++; end
    idle_inputs();
    checks++;
    if (nb !== 0) begin errors++; $display("FAIL ignore_len0: got %0d busy cycles want 0", nb); end
    len = $urandom_range(2, 4);
    tbm = 1'($urandom_range(0, 1));
    run_block(len, tbm, 2, -1, 1'b1);
    build_model(len, tbm);
    d = beat_diffs();
    checks++;
    if (d !== 0) begin errors++; $display("FAIL ignore_busy_beats: got %0d beats (%0d off) want %0d", act_beats.size(), d, exp_beats.size()); end
    checks++;
    if (n_done !== 1 || n_tb_start !== 1 || n_rst_sync !== 1) begin
      errors++; $display("FAIL ignore_busy_pulses: got done %0d tbs %0d rs %0d want 1 1 1", n_done, n_tb_start, n_rst_sync);
    end
  endtask

  task automatic test_abort();
    int cyc = 0, nd = 0, nrs = 0, d;
    bit hit = 1'b0;
    bus.block_len_i = 4; bus.sym_valid_i = 1'b1; bus.start_i = 1'b1;
    tick();
    bus.start_i = 1'b0;
    while (!hit && cyc < 100) begin
      if (bus.bm_valid_o && bus.step_o == 1 && bus.state_grp_o == 2) hit = 1'b1;
      else begin tick(); cyc++; end
    end
    checks++;
    if (!hit) begin errors++; $display("FAIL abort_reach: got no step1/grp2 want it within 100 cycles"); end
    bus.abort_i = 1'b1;
    tick();
    bus.abort_i = 1'b0;
    checks++;
    if ({bus.busy_o, bus.rst_sync_o, bus.bm_valid_o, bus.acs_en_o} !== 4'b0100) begin
      errors++; $display("FAIL abort_next: got busy/rs/bm/acs %b want 0100",
                         {bus.busy_o, bus.rst_sync_o, bus.bm_valid_o, bus.acs_en_o});
    end
    for (int i = 0; i < 6; i++) begin
      bus.tb_done_i = 1'($urandom_range(0, 1));
      tick();
      if (bus.done_o) nd++;
      if (bus.rst_sync_o) nrs++;
    end
    idle_inputs();
    checks++;
    if (nd !== 0 || nrs !== 0) begin errors++; $display("FAIL abort_after: got done %0d rs %0d want 0 0", nd, nrs); end
    // Abort colliding with traceback completion.
    bus.block_len_i = 1; bus.sym_valid_i = 1'b1; bus.start_i = 1'b1;
    tick();
    bus.start_i = 1'b0;
    cyc = 0;
    while (!bus.tb_start_o && cyc < 50) begin tick(); cyc++; end
    tick();
    bus.abort_i = 1'b1; bus.tb_done_i = 1'b1;
    tick();
    idle_inputs();
    nd = bus.done_o ? 1 : 0;
    tick();
    if (bus.done_o) nd++;
    checks++;
    if (nd !== 0 || bus.busy_o !== 1'b0) begin errors++; $display("FAIL abort_vs_tbdone: got done %0d busy %b want 0 0", nd, bus.busy_o); end
    run_block(1, 1'b0, 0, -1, 1'b0);
    build_model(1, 1'b0);
    d = beat_diffs();
    checks++;
    if (d !== 0 || n_done !== 1) begin errors++; $display("FAIL abort_restart: got %0d off done %0d want 0 1", d, n_done); end
  endtask

  task automatic test_norm();
    run_block(3, 1'b0, 0, 1, 1'b0);
`ifdef VITERBI_NORM_EN
    checks++;
    if (n_norm_beats !== 4 || first_norm_beat !== 4 || n_norm_other !== 0) begin
      errors++; $display("FAIL norm_window: got %0d beats from %0d (+%0d) want 4 from 4 (+0)", n_norm_beats, first_norm_beat, n_norm_other);
    end
`else
    checks++;
    if (n_norm_beats !== 0 || n_norm_other !== 0) begin
      errors++; $display("FAIL norm_tied: got %0d high cycles want 0", n_norm_beats + n_norm_other);
    end
`endif
  endtask

  initial begin
    test_reset();
    test_basic();
    test_tail_biting();
    test_stall();
    test_random();
    test_ignore();
    test_abort();
    test_norm();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
